// File: rtl/hazard_pkg.sv
// hazard_pkg: shared forwarding selects and MDU scoreboard state encoding
package hazard_pkg;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_t;
endpackage

// File: rtl/mdu_scoreboard.sv
// mdu_scoreboard: countdown tracker for the in-flight multi-cycle multiply/divide
module mdu_scoreboard import hazard_pkg::*; #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    output logic busy,
    output logic done,
    output logic err
);
    localparam int CW = $clog2(DIV_LAT);
    mdu_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    // State, countdown and sticky illegal-issue flag; reset abandons any operation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            err   <= err | (start && state != IDLE);
        end
    end
    // BUSY lasts LAT-1 cycles and DONE one more, so the unit is busy for exactly LAT cycles
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (start) begin
                state_n = BUSY;
                cnt_n   = div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
            end
            BUSY: begin
                cnt_n   = cnt - 1'b1;
                state_n = (cnt == CW'(1)) ? DONE : BUSY;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    assign busy = state != IDLE;
    assign done = state == DONE;
endmodule

// File: rtl/hazard_unit_mdu.sv
// hazard_unit_mdu: forwarding, stall and flush control for the five-stage pipeline with MDU tracking
module hazard_unit_mdu import hazard_pkg::*; #(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] RS_D,
    input  logic [REG_AW-1:0] RT_D,
    input  logic [REG_AW-1:0] RS_EX,
    input  logic [REG_AW-1:0] RT_EX,
    input  logic [REG_AW-1:0] WriteRegE,
    input  logic [REG_AW-1:0] WriteReg_M,
    input  logic [REG_AW-1:0] WriteReg_W,
    input  logic              RegWriteE,
    input  logic              RegWrite_M,
    input  logic              RegWrite_W,
    input  logic              MemToReg_E,
    input  logic              MemToReg_M,
    input  logic              BranchD,
    input  logic              JumpD,
    input  logic              PCSrcD,
    input  logic              MduStartD,
    input  logic              MduStartE,
    input  logic              MduDivE,
    input  logic              HiLoReadD,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushE,
    output logic              FlushD,
    output logic              MduBusy,
    output logic              MduDone,
    output logic              MduErr
);
    logic lw_stall, branch_stall, mdu_stall, stall;
    function automatic logic hit(input logic [REG_AW-1:0] dst, input logic [REG_AW-1:0] src);
        return dst != '0 && dst == src;
    endfunction
    mdu_scoreboard #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_sb (
        .clk   (clk),
        .reset (reset),
        .start (MduStartE),
        .div   (MduDivE),
        .busy  (MduBusy),
        .done  (MduDone),
        .err   (MduErr)
    );
    // Operand bypass selects; MEM wins over WB since it holds the younger result
    always_comb begin
        ForwardAE = (RegWrite_M && hit(WriteReg_M, RS_EX)) ? FWD_MEM :
                    (RegWrite_W && hit(WriteReg_W, RS_EX)) ? FWD_WB : FWD_RF;
        ForwardBE = (RegWrite_M && hit(WriteReg_M, RT_EX)) ? FWD_MEM :
                    (RegWrite_W && hit(WriteReg_W, RT_EX)) ? FWD_WB : FWD_RF;
        ForwardAD = RegWrite_M && hit(WriteReg_M, RS_D);
        ForwardBD = RegWrite_M && hit(WriteReg_M, RT_D);
    end
    // Load-use, branch-compare and MDU-occupancy stalls share one freeze/bubble signal
    always_comb begin
        lw_stall     = MemToReg_E && (hit(WriteRegE, RS_D) || hit(WriteRegE, RT_D));
        branch_stall = BranchD && ((RegWriteE && (hit(WriteRegE, RS_D) || hit(WriteRegE, RT_D))) ||
                                   (MemToReg_M && (hit(WriteReg_M, RS_D) || hit(WriteReg_M, RT_D))));
        mdu_stall    = (HiLoReadD || MduStartD) && MduBusy;
        stall        = lw_stall | branch_stall | mdu_stall;
        StallF       = stall;
        StallD       = stall;
        FlushE       = stall;
        FlushD       = (PCSrcD | JumpD) & ~stall;
    end
endmodule

// File: tb/tb_hazard_unit_mdu.sv
// tb_hazard_unit_mdu: randomized scoreboard bench for hazard_unit_mdu
module tb_hazard_unit_mdu;
    localparam int AW = 5;
    localparam int ML = 4;
    localparam int DL = 32;
    logic clk = 1'b0;
    logic reset;
    logic [AW-1:0] RS_D, RT_D, RS_EX, RT_EX, WriteRegE, WriteReg_M, WriteReg_W;
    logic RegWriteE, RegWrite_M, RegWrite_W, MemToReg_E, MemToReg_M;
    logic BranchD, JumpD, PCSrcD, MduStartD, MduStartE, MduDivE, HiLoReadD;
    logic [1:0] ForwardAE, ForwardBE;
    logic ForwardAD, ForwardBD, StallF, StallD, FlushE, FlushD, MduBusy, MduDone, MduErr;

    typedef struct {
        logic [1:0] fae, fbe;
        logic fad, fbd, stall, flushd, busy, done, err;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;
    int busy_left = 0;
    logic err_m = 1'b0;

    always #5 clk = ~clk;

    hazard_unit_mdu #(.REG_AW(AW), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .reset(reset),
        .RS_D(RS_D), .RT_D(RT_D), .RS_EX(RS_EX), .RT_EX(RT_EX),
        .WriteRegE(WriteRegE), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
        .RegWriteE(RegWriteE), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .MemToReg_E(MemToReg_E), .MemToReg_M(MemToReg_M),
        .BranchD(BranchD), .JumpD(JumpD), .PCSrcD(PCSrcD),
        .MduStartD(MduStartD), .MduStartE(MduStartE), .MduDivE(MduDivE), .HiLoReadD(HiLoReadD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .FlushD(FlushD),
        .MduBusy(MduBusy), .MduDone(MduDone), .MduErr(MduErr)
    );

    function automatic logic h(input logic [AW-1:0] a, input logic [AW-1:0] r);
        return a != '0 && a == r;
    endfunction

    function automatic logic [1:0] fwd(input logic [AW-1:0] r);
        if (RegWrite_M && h(WriteReg_M, r)) return 2'b10;
        if (RegWrite_W && h(WriteReg_W, r)) return 2'b01;
        return 2'b00;
    endfunction

    // Reference model: the MDU is a count of busy cycles left; retire is the last one
    task automatic push_exp();
        exp_t x;
        logic lw, br, md;
        if (!reset) begin
            busy_left = 0;
            err_m = 1'b0;
        end
        lw = MemToReg_E && (h(WriteRegE, RS_D) || h(WriteRegE, RT_D));
        br = BranchD && ((RegWriteE && (h(WriteRegE, RS_D) || h(WriteRegE, RT_D))) ||
                         (MemToReg_M && (h(WriteReg_M, RS_D) || h(WriteReg_M, RT_D))));
        md = (HiLoReadD || MduStartD) && busy_left > 0;
        x.fae = fwd(RS_EX);
        x.fbe = fwd(RT_EX);
        x.fad = RegWrite_M && h(WriteReg_M, RS_D);
        x.fbd = RegWrite_M && h(WriteReg_M, RT_D);
        x.stall = lw | br | md;
        x.flushd = (PCSrcD | JumpD) && !x.stall;
        x.busy = busy_left > 0;
        x.done = busy_left == 1;
        x.err = err_m;
        q.push_back(x);
        if (reset) begin
            if (MduStartE && busy_left > 0) err_m = 1'b1;
            if (busy_left > 0) busy_left--;
            else if (MduStartE) busy_left = MduDivE ? DL : ML;
        end
    endtask

    task automatic step();
        push_exp();
        @(posedge clk);
        #1;
    endtask

    task automatic zero();
        {RS_D, RT_D, RS_EX, RT_EX, WriteRegE, WriteReg_M, WriteReg_W} = '0;
        {RegWriteE, RegWrite_M, RegWrite_W, MemToReg_E, MemToReg_M} = '0;
        {BranchD, JumpD, PCSrcD, MduStartD, MduStartE, MduDivE, HiLoReadD} = '0;
    endtask

    task automatic chk(input string n, input logic [1:0] got, input logic [1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", n, got, want, $time);
        end
    endtask

    // Monitor: compare every cycle's outputs against the oldest queued expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("ForwardAE", ForwardAE, e.fae);
            chk("ForwardBE", ForwardBE, e.fbe);
            chk("ForwardAD", {1'b0, ForwardAD}, {1'b0, e.fad});
            chk("ForwardBD", {1'b0, ForwardBD}, {1'b0, e.fbd});
            chk("StallF", {1'b0, StallF}, {1'b0, e.stall});
            chk("StallD", {1'b0, StallD}, {1'b0, e.stall});
            chk("FlushE", {1'b0, FlushE}, {1'b0, e.stall});
            chk("FlushD", {1'b0, FlushD}, {1'b0, e.flushd});
            chk("MduBusy", {1'b0, MduBusy}, {1'b0, e.busy});
            chk("MduDone", {1'b0, MduDone}, {1'b0, e.done});
            chk("MduErr", {1'b0, MduErr}, {1'b0, e.err});
        end
    end

    initial begin
        reset = 1'b0;
        zero();
        @(posedge clk);
        #1;
        repeat (2) step();
        reset = 1'b1;
        step();
        RS_EX = 5; RegWrite_M = 1; WriteReg_M = 5; RegWrite_W = 1; WriteReg_W = 5;
        step();
        RS_EX = 0; step();
        RS_EX = 5; RegWrite_M = 0; RT_EX = 5; step();
        zero();
        MemToReg_E = 1; WriteRegE = 8; RT_D = 8; PCSrcD = 1; step();
        MemToReg_E = 0; step();
        zero();
        BranchD = 1; RegWriteE = 1; WriteRegE = 3; RS_D = 3; step();
        WriteRegE = 0; RS_D = 0; step();
        RegWriteE = 0; MemToReg_M = 1; WriteReg_M = 7; RT_D = 7; step();
        zero();
        MduStartE = 1; HiLoReadD = 1; step();
        MduStartE = 0; repeat (6) step();
        zero();
        MduStartE = 1; MduDivE = 1; step();
        MduStartE = 0; repeat (10) step();
        MduStartE = 1; MduDivE = 0; step();
        MduStartE = 0; repeat (25) step();
        zero();
        MduStartE = 1; MduDivE = 1; step();
        MduStartE = 0; repeat (4) step();
        reset = 1'b0; step();
        step();
        reset = 1'b1; step();
        MduStartE = 1; MduDivE = 0; step();
        MduStartE = 0; MduStartD = 1; repeat (6) step();
        for (int i = 0; i < 2000; i++) begin
            RS_D = AW'($urandom_range(0, 3)); RT_D = AW'($urandom_range(0, 3));
            RS_EX = AW'($urandom_range(0, 3)); RT_EX = AW'($urandom_range(0, 3));
            WriteRegE = AW'($urandom_range(0, 3)); WriteReg_M = AW'($urandom_range(0, 3));
            WriteReg_W = AW'($urandom_range(0, 3));
            RegWriteE = 1'($urandom_range(0, 1)); RegWrite_M = 1'($urandom_range(0, 1));
            RegWrite_W = 1'($urandom_range(0, 1)); MemToReg_E = 1'($urandom_range(0, 1));
            MemToReg_M = 1'($urandom_range(0, 1)); BranchD = 1'($urandom_range(0, 1));
            JumpD = 1'($urandom_range(0, 1)); PCSrcD = 1'($urandom_range(0, 1));
            MduStartD = 1'($urandom_range(0, 1)); HiLoReadD = 1'($urandom_range(0, 1));
            MduStartE = $urandom_range(0, 15) == 0; MduDivE = 1'($urandom_range(0, 1));
            reset = $urandom_range(0, 199) != 0;
            step();
        end
        zero();
        reset = 1'b1;
        step();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
